// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the single arithmetic slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic half_s;

    assign half_s = a ^ b;
    assign sum    = half_s ^ c_in;
    assign c_out  = (a & b) | (c_in & half_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder processes operand bits LSB first, one bit per clock,
// and the finished sum is published only on the completion edge.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_nx_s;
    logic             done_nx_s;
    logic             accept_s;
    logic             last_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             fa_sum_s;
    logic             fa_cout_s;

    // A start is taken in IDLE or DONE; start during SHIFT never reaches the datapath.
    assign accept_s = (state_r != SHIFT) && (state_nx_s == SHIFT);
    assign last_s   = (state_r == SHIFT) && (cnt_r == LAST_CNT);

    full_adder u_fa (
        .a     (a_r[0]),
        .b     (b_r[0]),
        .c_in  (carry_r),
        .sum   (fa_sum_s),
        .c_out (fa_cout_s)
    );

    // FSM state register and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Status flags decoded from the next state so they leave the block straight from flops
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            SHIFT: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b0;
            end
            DONE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Operand load, per-bit shift/accumulate, and result publication on the final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            acc_r   <= '0;
            carry_r <= c_in;
            cnt_r   <= '0;
        end else if (state_r == SHIFT) begin
            a_r     <= {1'b0, a_r[WIDTH-1:1]};
            b_r     <= {1'b0, b_r[WIDTH-1:1]};
            acc_r   <= {fa_sum_s, acc_r[WIDTH-1:1]};
            carry_r <= fa_cout_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            if (last_s) begin
                sum_r  <= {fa_sum_s, acc_r[WIDTH-1:1]};
                cout_r <= fa_cout_s;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign c_out = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16: directed vectors,
// multi-cycle corner sequences and randomised operations against an arithmetic model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, cin8, busy8, done8, co8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, co16;
    logic [15:0] a16, b16, sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c_in(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .c_out(co16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_co;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input bit w);
        return w ? done16 : done8;
    endfunction

    function automatic logic get_busy(input bit w);
        return w ? busy16 : busy8;
    endfunction

    function automatic logic [31:0] get_sum(input bit w);
        return w ? {16'h0000, sum16} : {24'h000000, sum8};
    endfunction

    function automatic logic get_co(input bit w);
        return w ? co16 : co8;
    endfunction

    task automatic drive(input bit w, input logic st, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        if (w) begin
            start16 = st; a16 = a[15:0]; b16 = b[15:0]; cin16 = c;
        end else begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = c;
        end
    endtask

    // Called just after a falling edge. Launches one addition, scrambles operands while
    // busy, and checks latency, busy length and that the published sum holds until done.
    task automatic run_op(input bit w, input logic [31:0] a, input logic [31:0] b, input logic c,
                          output logic [31:0] s, output logic co);
        int          width;
        int          lat;
        int          bcnt;
        bit          seen;
        bit          stable;
        logic [31:0] prev_s;
        logic        prev_co;
        width   = w ? 16 : 8;
        lat     = 0;
        bcnt    = 0;
        seen    = 1'b0;
        stable  = 1'b1;
        s       = 32'h0;
        co      = 1'b0;
        prev_s  = get_sum(w);
        prev_co = get_co(w);
        drive(w, 1'b1, a, b, c);
        @(posedge clk);
        for (int j = 1; j <= 4 * width && !seen; j++) begin
            @(negedge clk);
            drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
            if (get_done(w)) begin
                seen = 1'b1;
                lat  = j;
                s    = get_sum(w);
                co   = get_co(w);
                if (get_busy(w)) stable = 1'b0;
            end else begin
                if (get_busy(w)) bcnt++;
                if (get_sum(w) !== prev_s || get_co(w) !== prev_co) stable = 1'b0;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(width + 1));
        chk("busy_cycles", 32'(bcnt), 32'(width));
        chk("sum_held", 32'(stable), 32'd1);
    endtask

    vec_t        vecs[8];
    logic [31:0] rs;
    logic        rco;
    int          ndone;
    int          last_idx;
    bit          okflag;
    logic [63:0] model;
    logic [31:0] ra, rb, mask;
    logic        rc;

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out8", {28'h0, busy8, done8, co8, |sum8}, 32'h0);
        chk("reset_out16", {28'h0, busy16, done16, co16, |sum16}, 32'h0);

        // Release on a falling edge and start at once: the very next edge must accept.
        rst = 1'b0;
        foreach (vecs[i]) begin
            run_op(1'b0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, rs, rco);
            chk($sformatf("vec%0d_sum", i), rs, 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_co", i), 32'(rco), 32'(vecs[i].exp_co));
        end
        @(negedge clk);

        // Start pulse during SHIFT must be ignored.
        drive(1'b0, 1'b1, 32'h3C, 32'h42, 1'b0);
        @(posedge clk);
        ndone = 0;
        rs    = 32'h0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 3) drive(1'b0, 1'b1, 32'hFF, 32'hFF, 1'b0);
            else        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            if (done8) begin
                ndone++;
                rs = 32'(sum8);
            end
        end
        chk("ignore_ndone", 32'(ndone), 32'd1);
        chk("ignore_sum", rs, 32'h7E);
        chk("ignore_held", {23'h0, co8, sum8}, 32'h07E);

        // Start held high: back-to-back operations, done every WIDTH+1 cycles.
        drive(1'b0, 1'b1, 32'h10, 32'h20, 1'b0);
        @(posedge clk);
        ndone    = 0;
        last_idx = 0;
        okflag   = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            @(negedge clk);
            if (busy8 === done8) okflag = 1'b0;
            if (done8) begin
                ndone++;
                if (sum8 !== 8'h30 || co8 !== 1'b0) okflag = 1'b0;
                if (j - last_idx != 9) okflag = 1'b0;
                last_idx = j;
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("b2b_ndone", 32'(ndone), 32'd4);
        chk("b2b_rules", 32'(okflag), 32'd1);
        @(negedge clk);

        // Reset mid-SHIFT: outputs clear immediately and the aborted op never signals done.
        run_op(1'b0, 32'hC3, 32'h11, 1'b0, rs, rco);
        chk("pre_abort_sum", rs, 32'hD4);
        drive(1'b0, 1'b1, 32'h55, 32'h22, 1'b0);
        @(posedge clk);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_clear", {23'h0, busy8, done8, co8, sum8}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        chk("abort_quiet", 32'(ndone), 32'd0);
        run_op(1'b0, 32'h01, 32'h02, 1'b0, rs, rco);
        chk("post_abort_sum", {rs[30:0], rco}, {32'h03, 1'b0} >> 0 & 32'h6);

        // Randomised operations at both widths against a+b+c_in.
        for (int w = 0; w < 2; w++) begin
            mask = (w == 1) ? 32'h0000FFFF : 32'h000000FF;
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom & mask;
                rb = $urandom & mask;
                rc = 1'($urandom);
                if (i % 10 == 0) ra = mask;
                if (i % 10 == 5) rb = mask - ra + 32'(!rc);
                model = 64'(ra) + 64'(rb) + 64'(rc);
                run_op(w[0], ra, rb, rc, rs, rco);
                chk($sformatf("rand_w%0d_sum", (w == 1) ? 16 : 8), rs, model[31:0] & mask);
                chk($sformatf("rand_w%0d_co", (w == 1) ? 16 : 8), 32'(rco),
                    (w == 1) ? 32'(model[16]) : 32'(model[8]));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
